// File: rtl/alu_pkg.sv
// Shared definitions for the register decoder.
// Holds the command mode encodings, the FSM state encodings and the default
// values for the select width and the scan dwell time.
package alu_pkg;

    localparam int unsigned SEL_W_DEF = 4;
    localparam int unsigned DWELL_DEF = 3;

    typedef enum logic [1:0] {
        ModeOneHot = 2'b00,
        ModeTherm  = 2'b01,
        ModeScan   = 2'b10,
        ModeRsvd   = 2'b11
    } mode_e;

    typedef enum logic [1:0] {
        StIdle   = 2'b00,
        StStatic = 2'b01,
        StScan   = 2'b10
    } state_e;

endpackage

// File: rtl/pattern_gen.sv
// Combinational pattern generator.
// Turns an index and a command mode into the decoded output vector.
// Ports:
//   mode    - command mode (one-hot and scan both give a one-hot vector)
//   index   - bit position to decode
//   pattern - one-hot, thermometer (bits 0..index) or all zeros (reserved)
module pattern_gen
    import alu_pkg::*;
#(
    parameter int unsigned SEL_W = SEL_W_DEF
) (
    input  mode_e                   mode,
    input  logic [SEL_W-1:0]        index,
    output logic [(2**SEL_W)-1:0]   pattern
);

    localparam int unsigned OUT_W = 2**SEL_W;

    always_comb begin
        pattern = '0;
        unique case (mode)
            ModeOneHot, ModeScan: pattern[index] = 1'b1;
            ModeTherm: begin
                for (int i = 0; i < OUT_W; i++) begin
                    pattern[i] = (i <= int'(index));
                end
            end
            default: pattern = '0;
        endcase
    end

endmodule

// File: rtl/reg_decoder.sv
// Registered decoder with one-hot, thermometer and scanning modes.
// Ports:
//   clk, rst        - clock and synchronous active-high reset
//   enable          - low forces idle and clears all outputs
//   mode, select    - command (mode, index), taken when in_valid and in_ready
//   in_valid        - command present
//   in_ready        - equals enable
//   out, out_valid  - registered pattern and its qualifier
//   oe              - tri-state output enable, equal to out_valid
//   scan_wrap       - pulse when the scan index wraps back to 0
//   mode_err        - pulse when a reserved-mode command is taken
module reg_decoder
    import alu_pkg::*;
#(
    parameter int unsigned SEL_W = SEL_W_DEF,
    parameter int unsigned DWELL = DWELL_DEF,
    localparam int unsigned OUT_W = 2**SEL_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic [1:0]        mode,
    input  logic [SEL_W-1:0]  select,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [OUT_W-1:0]  out,
    output logic              out_valid,
    output logic              oe,
    output logic              scan_wrap,
    output logic              mode_err
);

    localparam int unsigned DCNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [DCNT_W-1:0] DWELL_LAST = DCNT_W'(DWELL - 1);

    state_e              state_q, state_d;
    logic [SEL_W-1:0]    idx_q, idx_d;
    logic [DCNT_W-1:0]   dwell_q, dwell_d;
    logic [OUT_W-1:0]    out_q, out_d;
    logic                out_valid_q, out_valid_d;
    logic                scan_wrap_q, scan_wrap_d;
    logic                mode_err_q, mode_err_d;

    mode_e               cmd_mode;
    logic                accept;
    logic [SEL_W-1:0]    idx_adv;
    mode_e               pg_mode;
    logic [SEL_W-1:0]    pg_idx;
    logic [OUT_W-1:0]    pg_pattern;

    assign cmd_mode = mode_e'(mode);
    assign accept   = enable & in_valid;
    // Index wraps naturally since OUT_W == 2**SEL_W.
    assign idx_adv  = idx_q + SEL_W'(1);

    // One generator serves both a new command and the next scan position.
    assign pg_mode  = accept ? cmd_mode : ModeScan;
    assign pg_idx   = accept ? select : idx_adv;

    pattern_gen #(
        .SEL_W (SEL_W)
    ) u_pattern_gen (
        .mode    (pg_mode),
        .index   (pg_idx),
        .pattern (pg_pattern)
    );

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        dwell_d     = dwell_q;
        out_d       = out_q;
        out_valid_d = out_valid_q;
        scan_wrap_d = 1'b0;
        mode_err_d  = 1'b0;

        if (!enable) begin
            state_d     = StIdle;
            idx_d       = '0;
            dwell_d     = '0;
            out_d       = '0;
            out_valid_d = 1'b0;
        end else if (in_valid) begin
            idx_d   = select;
            dwell_d = '0;
            out_d   = pg_pattern;
            unique case (cmd_mode)
                ModeOneHot, ModeTherm: begin
                    state_d     = StStatic;
                    out_valid_d = 1'b1;
                end
                ModeScan: begin
                    state_d     = StScan;
                    out_valid_d = 1'b1;
                end
                default: begin
                    state_d     = StIdle;
                    idx_d       = '0;
                    out_valid_d = 1'b0;
                    mode_err_d  = 1'b1;
                end
            endcase
        end else if (state_q == StScan) begin
            if (dwell_q == DWELL_LAST) begin
                dwell_d     = '0;
                idx_d       = idx_adv;
                out_d       = pg_pattern;
                scan_wrap_d = (idx_adv == '0);
            end else begin
                dwell_d = dwell_q + DCNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            idx_q       <= '0;
            dwell_q     <= '0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
            scan_wrap_q <= 1'b0;
            mode_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            dwell_q     <= dwell_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
            scan_wrap_q <= scan_wrap_d;
            mode_err_q  <= mode_err_d;
        end
    end

    assign in_ready  = enable;
    assign out       = out_q;
    assign out_valid = out_valid_q;
    assign oe        = out_valid_q;
    assign scan_wrap = scan_wrap_q;
    assign mode_err  = mode_err_q;

endmodule

// File: tb/tb_reg_decoder.sv
// Bench for reg_decoder: a default instance (SEL_W=4, DWELL=3) and a small
// instance (SEL_W=2, DWELL=1), checked every cycle against a command-level
// model plus literal expectations at key points.
module tb_reg_decoder;

    localparam int K_NONE   = 0;
    localparam int K_ONEHOT = 1;
    localparam int K_THERM  = 2;
    localparam int K_SCAN   = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b1;
    logic        enable = 1'b1;
    logic        in_valid = 1'b0;
    logic [1:0]  mode = 2'b00;
    logic [3:0]  select = 4'd0;
    logic        in_ready;
    logic [15:0] out;
    logic        out_valid, oe, scan_wrap, mode_err;

    logic        enable2 = 1'b1;
    logic        in_valid2 = 1'b0;
    logic [1:0]  mode2 = 2'b00;
    logic [1:0]  select2 = 2'd0;
    logic        in_ready2;
    logic [3:0]  out2;
    logic        out_valid2, oe2, scan_wrap2, mode_err2;

    reg_decoder dut (
        .clk       (clk),
        .rst       (rst),
        .enable    (enable),
        .mode      (mode),
        .select    (select),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out       (out),
        .out_valid (out_valid),
        .oe        (oe),
        .scan_wrap (scan_wrap),
        .mode_err  (mode_err)
    );

    reg_decoder #(
        .SEL_W (2),
        .DWELL (1)
    ) dut2 (
        .clk       (clk),
        .rst       (rst),
        .enable    (enable2),
        .mode      (mode2),
        .select    (select2),
        .in_valid  (in_valid2),
        .in_ready  (in_ready2),
        .out       (out2),
        .out_valid (out_valid2),
        .oe        (oe2),
        .scan_wrap (scan_wrap2),
        .mode_err  (mode_err2)
    );

    int n_cmp = 0;
    int n_fail = 0;

    // Model: the last accepted command and the cycles elapsed since it.
    int m_kind [2];
    int m_sel  [2];
    int m_age  [2];
    bit m_err  [2];
    bit started = 1'b0;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    function automatic int outw(input int id);
        return (id == 0) ? 16 : 4;
    endfunction

    function automatic int dwell(input int id);
        return (id == 0) ? 3 : 1;
    endfunction

    function automatic int scan_pos(input int id);
        return (m_sel[id] + m_age[id] / dwell(id)) % outw(id);
    endfunction

    function automatic logic [15:0] exp_out(input int id);
        logic [15:0] p;
        p = '0;
        case (m_kind[id])
            K_ONEHOT: p[m_sel[id]] = 1'b1;
            K_THERM:  for (int i = 0; i <= m_sel[id]; i++) p[i] = 1'b1;
            K_SCAN:   p[scan_pos(id)] = 1'b1;
            default:  p = '0;
        endcase
        return p;
    endfunction

    function automatic logic exp_wrap(input int id);
        return (m_kind[id] == K_SCAN) && (m_age[id] > 0) &&
               (m_age[id] % dwell(id) == 0) && (scan_pos(id) == 0);
    endfunction

    task automatic model_step(input int id, input logic r, input logic en, input logic v,
                              input logic [1:0] md, input int sel);
        if (r || !en) begin
            m_kind[id] = K_NONE;
            m_err[id]  = 1'b0;
        end else if (v) begin
            m_err[id]  = (md == 2'b11);
            m_kind[id] = (md == 2'b11) ? K_NONE : int'(md) + 1;
            m_sel[id]  = sel;
            m_age[id]  = 0;
        end else begin
            m_err[id] = 1'b0;
            m_age[id]++;
        end
    endtask

    always @(posedge clk) begin
        model_step(0, rst, enable, in_valid, mode, int'(select));
        model_step(1, rst, enable2, in_valid2, mode2, int'(select2));
        if (rst) started = 1'b1;
    end

    always @(negedge clk) begin
        if (started) begin
            chk("out",        out,                 exp_out(0));
            chk("out_valid",  16'(out_valid),      16'(m_kind[0] != K_NONE));
            chk("oe",         16'(oe),             16'(m_kind[0] != K_NONE));
            chk("scan_wrap",  16'(scan_wrap),      16'(exp_wrap(0)));
            chk("mode_err",   16'(mode_err),       16'(m_err[0]));
            chk("in_ready",   16'(in_ready),       16'(enable));
            chk("out2",       16'(out2),           exp_out(1));
            chk("out_valid2", 16'(out_valid2),     16'(m_kind[1] != K_NONE));
            chk("oe2",        16'(oe2),            16'(m_kind[1] != K_NONE));
            chk("scan_wrap2", 16'(scan_wrap2),     16'(exp_wrap(1)));
            chk("mode_err2",  16'(mode_err2),      16'(m_err[1]));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic cmd(input logic [1:0] md, input logic [3:0] sel);
        mode     = md;
        select   = sel;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
    endtask

    task automatic cmd2(input logic [1:0] md, input logic [1:0] sel);
        mode2     = md;
        select2   = sel;
        in_valid2 = 1'b1;
        step();
        in_valid2 = 1'b0;
    endtask

    initial begin
        repeat (3) step();
        rst = 1'b0;
        chk("lit_reset_out", out, 16'h0000);
        chk("lit_reset_valid", 16'(out_valid), 16'h0);

        // One-hot, held
        cmd(2'b00, 4'd5);
        chk("lit_onehot5", out, 16'h0020);
        chk("lit_onehot5_valid", 16'(out_valid), 16'h1);
        for (int i = 0; i < 10; i++) begin
            step();
            chk("lit_onehot5_hold", out, 16'h0020);
        end

        // Thermometer, including both ends
        cmd(2'b01, 4'd3);
        chk("lit_therm3", out, 16'h000F);
        cmd(2'b01, 4'd15);
        chk("lit_therm15", out, 16'hFFFF);
        cmd(2'b01, 4'd0);
        chk("lit_therm0", out, 16'h0001);

        // Scan across the wrap
        cmd(2'b10, 4'd14);
        chk("lit_scan14", out, 16'h4000);
        for (int i = 0; i < 2; i++) begin
            step();
            chk("lit_scan14_dwell", out, 16'h4000);
        end
        for (int i = 0; i < 3; i++) begin
            step();
            chk("lit_scan15", out, 16'h8000);
            chk("lit_scan15_nowrap", 16'(scan_wrap), 16'h0);
        end
        step();
        chk("lit_scan_wrap_out", out, 16'h0001);
        chk("lit_scan_wrap", 16'(scan_wrap), 16'h1);
        step();
        chk("lit_scan_wrap_once", 16'(scan_wrap), 16'h0);

        // Disable wins over a coincident command; no restore on re-enable
        cmd(2'b10, 4'd7);
        step();
        enable   = 1'b0;
        in_valid = 1'b1;
        mode     = 2'b00;
        select   = 4'd3;
        step();
        in_valid = 1'b0;
        chk("lit_disable_out", out, 16'h0000);
        chk("lit_disable_oe", 16'(oe), 16'h0);
        enable = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("lit_reenable_out", out, 16'h0000);
        end
        cmd(2'b00, 4'd2);
        chk("lit_after_reenable", out, 16'h0004);

        // Reserved mode
        cmd(2'b11, 4'd9);
        chk("lit_rsvd_err", 16'(mode_err), 16'h1);
        chk("lit_rsvd_out", out, 16'h0000);
        chk("lit_rsvd_valid", 16'(out_valid), 16'h0);
        step();
        chk("lit_rsvd_err_once", 16'(mode_err), 16'h0);

        // Reset on the edge that would otherwise wrap
        cmd(2'b10, 4'd15);
        step();
        step();
        rst = 1'b1;
        step();
        chk("lit_rst_scan_out", out, 16'h0000);
        chk("lit_rst_scan_wrap", 16'(scan_wrap), 16'h0);
        chk("lit_rst_scan_oe", 16'(oe), 16'h0);
        rst = 1'b0;
        step();

        // Small instance, DWELL=1
        cmd2(2'b10, 2'd0);
        chk("lit_s2_c1", 16'(out2), 16'h1);
        step();
        chk("lit_s2_c2", 16'(out2), 16'h2);
        step();
        chk("lit_s2_c3", 16'(out2), 16'h4);
        step();
        chk("lit_s2_c4", 16'(out2), 16'h8);
        chk("lit_s2_c4_nowrap", 16'(scan_wrap2), 16'h0);
        step();
        chk("lit_s2_c5", 16'(out2), 16'h1);
        chk("lit_s2_c5_wrap", 16'(scan_wrap2), 16'h1);
        step();
        chk("lit_s2_c6", 16'(out2), 16'h2);

        step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/reg_decoder.md
REG_DECODER -- requirements
Module: reg_decoder

Interface
REQ-001 Parameter SEL_W, default 4: select width in bits; legal range 1..6.
REQ-002 Parameter DWELL, default 3: scan-mode cycles spent on each output position; minimum 1.
REQ-003 Derived constant OUT_W = 2**SEL_W: output width; not overridable.
REQ-004 Port clk, input, 1: single clock; all state updates on its rising edge.
REQ-005 Port rst, input, 1: synchronous, active-high reset.
REQ-006 Port enable, input, 1: block enable; low forces idle and deasserted outputs.
REQ-007 Port mode, input, 2: command mode; 00 one-hot, 01 thermometer, 10 scan, 11 reserved.
REQ-008 Port select, input, SEL_W: command index.
REQ-009 Port in_valid, input, 1: command (mode, select) present.
REQ-010 Port in_ready, output, 1: block can accept a command.
REQ-011 Port out, output, OUT_W: registered decoded pattern.
REQ-012 Port out_valid, output, 1: out holds a decoded pattern.
REQ-013 Port oe, output, 1: output-enable for external tri-state drivers; equals out_valid.
REQ-014 Port scan_wrap, output, 1: one-cycle pulse when scan wraps from OUT_W-1 to 0.
REQ-015 Port mode_err, output, 1: one-cycle pulse when a reserved-mode command is accepted.

Function
REQ-016 in_ready SHALL equal enable combinationally; a command is accepted on an edge where in_valid, in_ready and not rst are all high.
REQ-017 FSM states SHALL be IDLE, STATIC and SCAN.
REQ-018 Accepted command, mode 00: the next-cycle out SHALL be one-hot with bit[select] set; out_valid=1; state STATIC.
REQ-019 Accepted command, mode 01: the next-cycle out SHALL have bits 0..select set and all others clear; out_valid=1; state STATIC.
REQ-020 Accepted command, mode 10: the next-cycle out SHALL be one-hot at index select; dwell counter=0; out_valid=1; state SCAN.
REQ-021 Accepted command, mode 11: out SHALL be all zeros; out_valid=0; mode_err pulses for one cycle; state IDLE.
REQ-022 Command latency SHALL be exactly one cycle from the accepting edge to the updated out.
REQ-023 STATIC: out SHALL hold until a new command is accepted, enable deasserts or reset occurs.
REQ-024 SCAN: dwell counter increments every cycle; when it reaches DWELL-1 it clears and the index advances by 1 modulo OUT_W.
REQ-025 SCAN wrap: on an advance from OUT_W-1 to 0, scan_wrap SHALL pulse high in the same cycle that out shows bit 0.
REQ-026 A new command accepted in any state SHALL preempt the current one immediately; the dwell counter restarts.
REQ-027 enable low at an edge: out=0, out_valid=0, dwell and index cleared, state IDLE; a coincident in_valid is ignored.
REQ-028 enable reasserting SHALL NOT restore the previous pattern; out stays 0 until a new command is accepted.
REQ-029 Every output SHALL be a register except in_ready; out SHALL never be X or Z.

Reset
REQ-030 While rst is high at an edge: out=0, out_valid=0, oe=0, scan_wrap=0, mode_err=0, dwell=0, index=0, state IDLE.
REQ-031 rst SHALL take priority over enable and in_valid; reset during SCAN aborts the scan with no scan_wrap pulse.

Structure
REQ-032 Mode encodings, FSM state encodings and the SEL_W/DWELL defaults SHALL live in shared package alu_pkg.
REQ-033 Pattern generation (index and mode to one-hot or thermometer vector) SHALL be a combinational sub-module pattern_gen, parametrised by SEL_W.
REQ-034 The RTL SHALL be synthesizable with no latches and no internal tri-states.

Verification
REQ-035 Defaults; enable=1; mode=00, select=5, one-cycle valid -> next cycle out=16'h0020, out_valid=1; value holds for 10 cycles.
REQ-036 mode=01, select=3 -> out=16'h000F; then select=15 -> out=16'hFFFF; then select=0 -> out=16'h0001.
REQ-037 DWELL=3, mode=10, select=14 -> out=16'h4000 for 3 cycles, then 16'h8000 for 3 cycles, then 16'h0001 with scan_wrap=1 for exactly one cycle.
REQ-038 Scan running; enable=0 in the same cycle as a valid command -> next cycle out=0, oe=0; enable back to 1 -> out stays 0 until a new command.
REQ-039 mode=11 command -> mode_err pulses once, out=0, out_valid=0; rst asserted mid-scan -> all outputs 0 next cycle, no scan_wrap.
REQ-040 SEL_W=2, DWELL=1, mode=10, select=0 -> out=1,2,4,8,1 on consecutive cycles, with scan_wrap on the 5th cycle.
